ahb_in_fifo: RTL and testbench

AHB-Lite slave that carries data into the M0 system from an external producer, the input counterpart to the coordinate output slave. The producer delivers 16-bit words over a four-phase DataValid/DataAck handshake. Words are buffered in a small FIFO that software drains through a pop-on-read data register. The block sits on the AHB-Lite bus beside the other peripheral slaves and is selected by the system address decoder.

---
 rtl/ahb_in_fifo.sv | 181 ++++++++++++++++++
 tb/tb_ahb_in_fifo.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_in_fifo.sv
// AHB-Lite input FIFO slave: buffers producer words from a four-phase DataValid/DataAck
// handshake and exposes them through a pop-on-read data register. Optional macro: AHB_IN_SYNC_EN.
`timescale 1ns/1ps

// state | meaning
// IDLE  | DataAck low, waiting for vld; pushes DataIn when not full
// ACK   | DataAck high, waiting for vld to fall before the next word
module ahb_in_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic        HREADY,
    input  logic        HSEL,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    input  logic [WIDTH-1:0] DataIn,
    input  logic        DataValid,
    output logic        DataAck
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } hs_state_t;

    hs_state_t        state;
    logic             wr_en;
    logic             rd_en;
    logic [1:0]       addr;
    logic [CW-1:0]    count;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             overflow_seen;
    logic             vld;
    logic             not_empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             flush;
    logic [31:0]      status;
    logic [31:0]      rdata;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             unused_ok;

    assign unused_ok = ^{HSIZE, HWDATA[31:1], HADDR[31:4], HADDR[1:0]};
    assign HREADYOUT = 1'b1;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_en <= 1'b0;
            rd_en <= 1'b0;
            addr  <= 2'd0;
        end else if (HREADY && HSEL && (HTRANS != 2'b00)) begin
            wr_en <= HWRITE;
            rd_en <= !HWRITE;
            addr  <= HADDR[3:2];
        end else begin
            wr_en <= 1'b0;
            rd_en <= 1'b0;
            addr  <= 2'd0;
        end
    end

`ifdef AHB_IN_SYNC_EN
    logic [1:0] vld_sync;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            vld_sync <= 2'b00;
        end else begin
            vld_sync <= {vld_sync[0], DataValid};
        end
    end

    assign vld = vld_sync[1];
`else
    assign vld = DataValid;
`endif

    assign not_empty = (count != '0);
    assign full      = (count == DEPTH_C);
    assign push      = (state == IDLE) && vld && !full;
    assign pop       = rd_en && (addr == 2'd0) && not_empty;
    assign flush     = wr_en && (addr == 2'd1) && HWDATA[0];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state         <= IDLE;
            DataAck       <= 1'b0;
            count         <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            overflow_seen <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (vld && !full) begin
                        state   <= ACK;
                        DataAck <= 1'b1;
                    end
                end
                ACK: begin
                    if (!vld) begin
                        state   <= IDLE;
                        DataAck <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    DataAck <= 1'b0;
                end
            endcase

            // Flush wins over a coincident push or pop; the handshake still completes.
            if (flush) begin
                count         <= '0;
                wr_ptr        <= '0;
                rd_ptr        <= '0;
                overflow_seen <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
                if ((state == IDLE) && vld && full) begin
                    overflow_seen <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (push) begin
            mem[wr_ptr] <= DataIn;
        end
    end

    always_comb begin
        status      = '0;
        status[0]   = not_empty;
        status[1]   = full;
        status[2]   = overflow_seen;
        status[8:4] = 5'(count);
    end

    always_comb begin
        rdata = '0;
        if (rd_en) begin
            case (addr)
                2'd0: begin
                    if (not_empty) begin
                        rdata[WIDTH-1:0] = mem[rd_ptr];
                    end
                end
                2'd1:    rdata = status;
                default: rdata = '0;
            endcase
        end
    end

    assign HRDATA = rdata;

endmodule

// File: tb/tb_ahb_in_fifo.sv
// Self-checking bench for ahb_in_fifo: directed scenarios plus a randomized mix of
// handshakes and bus accesses compared against a queue-based model.
`timescale 1ns/1ps

module tb_ahb_in_fifo;

    localparam int DEPTH = 4;
    localparam int WIDTH = 16;
`ifdef AHB_IN_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic             HCLK;
    logic             HRESETn;
    logic [31:0]      HADDR;
    logic [31:0]      HWDATA;
    logic [2:0]       HSIZE;
    logic [1:0]       HTRANS;
    logic             HWRITE;
    logic             HREADY;
    logic             HSEL;
    logic [31:0]      HRDATA;
    logic             HREADYOUT;
    logic [WIDTH-1:0] DataIn;
    logic             DataValid;
    logic             DataAck;

    int errors = 0;
    int checks = 0;
    int q[$];
    bit ovf = 0;

    ahb_in_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HWDATA(HWDATA),
        .HSIZE(HSIZE), .HTRANS(HTRANS), .HWRITE(HWRITE), .HREADY(HREADY),
        .HSEL(HSEL), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
        .DataIn(DataIn), .DataValid(DataValid), .DataAck(DataAck)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        int n;
        n = q.size();
        return 32'((n << 4) | (ovf ? 4 : 0) | ((n == DEPTH) ? 2 : 0) | ((n != 0) ? 1 : 0));
    endfunction

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {28'h0, a, 2'b00};
        step();
        HSEL = 1'b0; HTRANS = 2'b00;
        d = HRDATA;
        step();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] wd);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {28'h0, a, 2'b00};
        step();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
        HWDATA = wd;
        step();
    endtask

    task automatic wait_ack(input logic v, input string tag);
        int n;
        n = 0;
        while (DataAck !== v && n < 20) begin
            step();
            n++;
        end
        check(tag, 32'(DataAck), 32'(v));
    endtask

    task automatic push_word(input logic [WIDTH-1:0] w);
        DataIn = w;
        DataValid = 1'b1;
        wait_ack(1'b1, "ack_rise");
        DataValid = 1'b0;
        wait_ack(1'b0, "ack_fall");
        q.push_back(int'(w));
    endtask

    task automatic read_pop(input string tag);
        logic [31:0] d;
        logic [31:0] e;
        bus_read(2'd0, d);
        e = (q.size() != 0) ? 32'(q.pop_front()) : 32'h0;
        check(tag, d, e);
    endtask

    task automatic read_status(input string tag);
        logic [31:0] d;
        bus_read(2'd1, d);
        check(tag, d, exp_status());
    endtask

    task automatic overflow_attempt(input logic [WIDTH-1:0] w);
        DataIn = w;
        DataValid = 1'b1;
        repeat (3 + SYNC_LAT) step();
        check("ovf_no_ack", 32'(DataAck), 32'h0);
        ovf = 1'b1;
        DataValid = 1'b0;
        repeat (SYNC_LAT + 2) step();
    endtask

    initial begin
        logic [31:0] d;
        logic [WIDTH-1:0] w5;
        int op;

        HRESETn = 1'b0; HADDR = '0; HWDATA = '0; HSIZE = 3'b010; HTRANS = 2'b00;
        HWRITE = 1'b0; HREADY = 1'b1; HSEL = 1'b0; DataIn = '0; DataValid = 1'b0;
        repeat (3) step();
        HRESETn = 1'b1;
        step();

        // Reset state
        check("rst_hreadyout", 32'(HREADYOUT), 32'h1);
        check("rst_ack", 32'(DataAck), 32'h0);
        check("rst_hrdata", HRDATA, 32'h0);
        bus_read(2'd1, d);
        check("rst_status", d, 32'h0);
        bus_read(2'd0, d);
        check("rst_data", d, 32'h0);

        // Three words, drained by back-to-back reads
        push_word(16'h1234);
        push_word(16'hABCD);
        push_word(16'h0001);
        read_status("status_3");
        check("status_3_lit", exp_status(), 32'h31);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h0;
        step();
        check("b2b_0", HRDATA, 32'h1234);
        step();
        check("b2b_1", HRDATA, 32'hABCD);
        step();
        HSEL = 1'b0; HTRANS = 2'b00;
        check("b2b_2", HRDATA, 32'h0001);
        step();
        q.delete();
        read_status("status_0");
        read_pop("empty_pop");
        read_status("status_0_again");

        // Fill, overflow with the fifth word held pending
        for (int i = 0; i < DEPTH; i++) push_word(WIDTH'($urandom));
        w5 = WIDTH'($urandom);
        DataIn = w5;
        DataValid = 1'b1;
        repeat (3 + SYNC_LAT) step();
        check("full_no_ack", 32'(DataAck), 32'h0);
        ovf = 1'b1;
        bus_read(2'd1, d);
        check("full_status", d, 32'h47);
        read_pop("full_pop");
        wait_ack(1'b1, "pending_ack");
        q.push_back(int'(w5));
        DataValid = 1'b0;
        wait_ack(1'b0, "pending_ack_fall");
        read_status("refill_status");
        for (int i = 0; i < DEPTH; i++) read_pop("drain");
        bus_write(2'd1, 32'h1);
        ovf = 1'b0;
        q.delete();
        read_status("flush_status");

        // DataValid held high: exactly one word, ack falls after the sync latency
        DataIn = 16'h5A5A;
        DataValid = 1'b1;
        wait_ack(1'b1, "hold_ack");
        repeat (5) step();
        q.push_back(32'h5A5A);
        read_status("hold_one_word");
        DataValid = 1'b0;
        for (int i = 0; i < SYNC_LAT; i++) begin
            step();
            check("hold_ack_still", 32'(DataAck), 32'h1);
        end
        step();
        check("hold_ack_drop", 32'(DataAck), 32'h0);
        repeat (2) step();
        read_pop("hold_pop");

        // Flush coincident with a push
        push_word(16'h1111);
        push_word(16'h2222);
        DataIn = 16'h3333;
        if (SYNC_LAT > 0) begin
            DataValid = 1'b1;
            repeat (SYNC_LAT - 1) step();
        end
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h4;
        step();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h1;
        DataValid = 1'b1;
        step();
        check("flush_push_ack", 32'(DataAck), 32'h1);
        DataValid = 1'b0;
        wait_ack(1'b0, "flush_push_ack_fall");
        q.delete();
        ovf = 1'b0;
        bus_read(2'd1, d);
        check("flush_push_status", d, 32'h0);

        // Reset mid-handshake with two words buffered
        push_word(16'hBEEF);
        push_word(16'hCAFE);
        DataIn = 16'h7777;
        DataValid = 1'b1;
        wait_ack(1'b1, "pre_rst_ack");
        HRESETn = 1'b0;
        #1;
        check("rst_mid_ack", 32'(DataAck), 32'h0);
        DataValid = 1'b0;
        repeat (2) step();
        HRESETn = 1'b1;
        step();
        q.delete();
        ovf = 1'b0;
        read_status("post_rst_status");
        push_word(16'h4242);
        read_pop("post_rst_pop");

        // Randomized mix against the queue model
        for (int it = 0; it < 80; it++) begin
            op = int'($urandom_range(0, 4));
            case (op)
                0, 1: begin
                    if (q.size() < DEPTH) push_word(WIDTH'($urandom));
                    else overflow_attempt(WIDTH'($urandom));
                end
                2: read_pop("rnd_pop");
                3: read_status("rnd_status");
                default: begin
                    case ($urandom_range(0, 3))
                        0: begin
                            bus_write(2'd0, $urandom);
                            read_status("rnd_wr0_ignored");
                        end
                        1: begin
                            bus_write(2'd1, 32'h0);
                            read_status("rnd_wr1_noflush");
                        end
                        2: begin
                            bus_read(2'd2, d);
                            check("rnd_addr2", d, 32'h0);
                        end
                        default: begin
                            bus_read(2'd3, d);
                            check("rnd_addr3", d, 32'h0);
                        end
                    endcase
                end
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
